// File: rtl/alu_arbiter_pkg.sv
// alu_arbiter_pkg
// Shared definitions for the two-requester ALU arbiter slice:
//   - 3-bit ALU op-code constants (AND .. SLT)
//   - FSM state enum used by the arbiter control
//   - width of the completed-transaction counter
//   - small helper turning a requester id into a one-hot 2-bit vector
package alu_arbiter_pkg;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_NOR = 3'b100;
  localparam logic [2:0] OP_SRL = 3'b101;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Requester id 0 maps to 2'b01, id 1 maps to 2'b10.
  function automatic logic [1:0] id_to_onehot(input logic id);
    return id ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/alu_arbiter_alu.sv
// alu_arbiter_alu
// Purely combinational 32-bit ALU shared by both requesters.
// Ports:
//   op     - 3-bit operation code (see alu_arbiter_pkg)
//   a, b   - 32-bit operands
//   result - 32-bit result
// SLT reports the sign bit of the wrapped difference A-B, not a full
// signed comparison.
module alu_arbiter_alu
  import alu_arbiter_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result
);

  logic [31:0] diff;

  // Decode the op code into one of the eight ALU functions; the
  // difference is shared between SUB and SLT.
  always_comb begin
    diff   = a - b;
    result = '0;
    case (op)
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_ADD:  result = a + b;
      OP_XOR:  result = a ^ b;
      OP_NOR:  result = ~(a | b);
      OP_SRL:  result = a >> b;
      OP_SUB:  result = diff;
      OP_SLT:  result = {31'b0, diff[31]};
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter
// Arbitrates two requesters onto one shared ALU. A transaction is
// accepted in IDLE, computed in EXEC and returned in RESP until the
// owning requester takes it.
// Parameters:
//   PRI_FIXED - 0: round-robin between requesters, 1: requester 0 always wins
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   req_valid/req_ready - per-requester request handshake (bit i = requester i)
//   req_op0/a0/b0       - op code and operands of requester 0
//   req_op1/a1/b1       - op code and operands of requester 1
//   rsp_valid/rsp_ready - per-requester response handshake (rsp_valid one-hot)
//   rsp_res/zero/ovf    - registered result, zero flag, signed overflow flag
//   busy                - high in any state other than IDLE
//   op_cnt              - saturating count of completed transactions
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter bit PRI_FIXED = 1'b0
)
(
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [2:0]       req_op0,
  input  logic [31:0]      req_a0,
  input  logic [31:0]      req_b0,
  input  logic [2:0]       req_op1,
  input  logic [31:0]      req_a1,
  input  logic [31:0]      req_b1,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [31:0]      rsp_res,
  output logic             rsp_zero,
  output logic             rsp_ovf,
  output logic             busy,
  output logic [CNT_W-1:0] op_cnt
);

  state_t           state_q, state_d;
  logic             owner_q;
  logic             prio_q;
  logic [2:0]       op_q;
  logic [31:0]      a_q, b_q;
  logic [31:0]      res_q;
  logic             zero_q, ovf_q;
  logic [CNT_W-1:0] op_cnt_q, op_cnt_nxt;

  logic [1:0]       grant;
  logic             grant_id;
  logic             accept;
  logic             done;
  logic [31:0]      alu_res;
  logic             ovf_calc;

  // Pick the winner among the valid requesters. When both ask, either
  // requester 0 wins outright or the round-robin priority bit decides;
  // prio_q names the requester that was not served last.
  always_comb begin
    grant    = 2'b00;
    grant_id = 1'b0;
    case (req_valid)
      2'b01: begin
        grant_id = 1'b0;
        grant    = 2'b01;
      end
      2'b10: begin
        grant_id = 1'b1;
        grant    = 2'b10;
      end
      2'b11: begin
        grant_id = PRI_FIXED ? 1'b0 : prio_q;
        grant    = id_to_onehot(grant_id);
      end
      default: begin
        grant_id = 1'b0;
        grant    = 2'b00;
      end
    endcase
  end

  // Next-state and handshake outputs. Handshakes are only offered in
  // their own state, and reset masks them immediately so nothing is
  // accepted or delivered while rst is high.
  always_comb begin
    state_d   = state_q;
    req_ready = 2'b00;
    rsp_valid = 2'b00;
    accept    = 1'b0;
    done      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready = grant;
        if (|req_valid) begin
          accept  = 1'b1;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        state_d = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid = id_to_onehot(owner_q);
        if (rsp_ready[owner_q]) begin
          done    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (rst) begin
      req_ready = 2'b00;
      rsp_valid = 2'b00;
      accept    = 1'b0;
      done      = 1'b0;
    end
  end

  // The ALU only ever sees the registered operands, so requesters may
  // change their inputs freely once accepted.
  alu_arbiter_alu u_alu (
    .op     (op_q),
    .a      (a_q),
    .b      (b_q),
    .result (alu_res)
  );

  // Signed overflow for ADD and SUB, judged from the operand signs and
  // the sign of the ALU result.
  always_comb begin
    ovf_calc = 1'b0;
    case (op_q)
      OP_ADD:  ovf_calc = (a_q[31] == b_q[31]) && (alu_res[31] != a_q[31]);
      OP_SUB:  ovf_calc = (a_q[31] != b_q[31]) && (alu_res[31] != a_q[31]);
      default: ovf_calc = 1'b0;
    endcase
  end

  // Saturating completion counter; the register is rewritten every cycle
  // from its own value so it always holds a self-consistent count.
  always_comb begin
    op_cnt_nxt = op_cnt_q;
    if (done && (op_cnt_q != {CNT_W{1'b1}})) begin
      op_cnt_nxt = op_cnt_q + 1'b1;
    end
  end

  // State, captured request, registered result and round-robin pointer.
  // The pointer moves only when a response completes, handing priority
  // to the requester that was just not served.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      owner_q  <= 1'b0;
      prio_q   <= 1'b0;
      op_q     <= OP_AND;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
      op_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      op_cnt_q <= op_cnt_nxt;
      if (accept) begin
        owner_q <= grant_id;
        op_q    <= grant_id ? req_op1 : req_op0;
        a_q     <= grant_id ? req_a1  : req_a0;
        b_q     <= grant_id ? req_b1  : req_b0;
      end
      if (state_q == ST_EXEC) begin
        res_q  <= alu_res;
        zero_q <= (alu_res == 32'd0);
        ovf_q  <= ovf_calc;
      end
      if (done) begin
        prio_q <= ~owner_q;
      end
    end
  end

  assign rsp_res  = res_q;
  assign rsp_zero = zero_q;
  assign rsp_ovf  = ovf_q;
  assign busy     = (state_q != ST_IDLE);
  assign op_cnt   = op_cnt_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter
// Self-checking bench for alu_arbiter. A round-robin instance is the main
// target; a fixed-priority instance shares the request inputs and always
// accepts responses, and is compared only while both run in lockstep.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [2:0]  req_op0, req_op1;
  logic [31:0] req_a0, req_b0, req_a1, req_b1;
  logic [1:0]  rsp_ready;

  logic [1:0]  req_ready, rsp_valid;
  logic [31:0] rsp_res;
  logic        rsp_zero, rsp_ovf, busy;
  logic [15:0] op_cnt;

  logic [1:0]  req_ready_fix, rsp_valid_fix;
  logic [31:0] rsp_res_fix;
  logic        rsp_zero_fix, rsp_ovf_fix, busy_fix;
  logic [15:0] op_cnt_fix;

  int          err_cnt = 0;
  int          chk_cnt = 0;
  int          m_cnt;
  logic        m_prio;

  logic [1:0]  r_valid;
  logic [2:0]  r_op0, r_op1;
  logic [31:0] r_a0, r_b0, r_a1, r_b1;

  always #5 clk = ~clk;

  alu_arbiter #(.PRI_FIXED(1'b0)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op0(req_op0), .req_a0(req_a0), .req_b0(req_b0),
    .req_op1(req_op1), .req_a1(req_a1), .req_b1(req_b1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_res(rsp_res), .rsp_zero(rsp_zero), .rsp_ovf(rsp_ovf),
    .busy(busy), .op_cnt(op_cnt)
  );

  alu_arbiter #(.PRI_FIXED(1'b1)) dut_fix (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready_fix),
    .req_op0(req_op0), .req_a0(req_a0), .req_b0(req_b0),
    .req_op1(req_op1), .req_a1(req_a1), .req_b1(req_b1),
    .rsp_valid(rsp_valid_fix), .rsp_ready(2'b11),
    .rsp_res(rsp_res_fix), .rsp_zero(rsp_zero_fix), .rsp_ovf(rsp_ovf_fix),
    .busy(busy_fix), .op_cnt(op_cnt_fix)
  );

  // Compare one observed value against its expectation and count it.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    chk_cnt++;
    if (actual !== expected) begin
      err_cnt++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, actual, expected, $time);
    end
  endtask

  // Drive both requesters' request inputs.
  task automatic applyStimulus(input logic [1:0] valid,
                               input logic [2:0] op0, input logic [31:0] a0, input logic [31:0] b0,
                               input logic [2:0] op1, input logic [31:0] a1, input logic [31:0] b1);
    req_valid = valid;
    req_op0   = op0;
    req_a0    = a0;
    req_b0    = b0;
    req_op1   = op1;
    req_a1    = a1;
    req_b1    = b1;
  endtask

  // Reference ALU: returns {ovf, result}. Overflow is judged by doing the
  // arithmetic on 64-bit signed values and checking the 32-bit range.
  function automatic logic [32:0] ref_alu(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    longint      sa, sb, wide;
    logic [31:0] r;
    logic        v;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    v  = 1'b0;
    r  = '0;
    case (op)
      3'd0: r = a & b;
      3'd1: r = a | b;
      3'd2: begin
        r    = a + b;
        wide = sa + sb;
        v    = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
      end
      3'd3: r = a ^ b;
      3'd4: r = ~(a | b);
      3'd5: r = (b >= 32'd32) ? 32'd0 : (a >> b);
      3'd6: begin
        r    = a - b;
        wide = sa - sb;
        v    = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
      end
      default: begin
        r = a - b;
        r = (r >> 31) & 32'd1;
      end
    endcase
    return {v, r};
  endfunction

  // Grant the model expects for a given request pattern (round-robin).
  function automatic logic model_id(input logic [1:0] valid);
    if (valid == 2'b11) return m_prio;
    return (valid == 2'b10);
  endfunction

  // One full transaction on the main instance: request, EXEC, RESP with
  // an optional stall, then completion. keep leaves req_valid asserted
  // afterwards; chk_fix also compares the fixed-priority grant.
  task automatic runTxn(input logic [1:0] valid,
                        input logic [2:0] op0, input logic [31:0] a0, input logic [31:0] b0,
                        input logic [2:0] op1, input logic [31:0] a1, input logic [31:0] b1,
                        input int hold, input bit keep, input bit chk_fix);
    logic        id;
    logic [1:0]  exp_grant;
    logic [32:0] exp;
    logic [31:0] held_res;
    @(negedge clk);
    applyStimulus(valid, op0, a0, b0, op1, a1, b1);
    rsp_ready = 2'b00;
    id        = model_id(valid);
    exp_grant = id ? 2'b10 : 2'b01;
    exp       = id ? ref_alu(op1, a1, b1) : ref_alu(op0, a0, b0);
    #1;
    checkOutput("idle_req_ready", 32'(req_ready), 32'(exp_grant));
    if (chk_fix) checkOutput("fixed_grant", 32'(req_ready_fix), 32'd1);

    @(posedge clk); #1;
    checkOutput("exec_busy", 32'(busy), 32'd1);
    checkOutput("exec_req_ready", 32'(req_ready), 32'd0);
    checkOutput("exec_rsp_valid", 32'(rsp_valid), 32'd0);
    applyStimulus(keep ? valid : 2'($urandom_range(0, 3)),
                  3'($urandom_range(0, 7)), $urandom, $urandom,
                  3'($urandom_range(0, 7)), $urandom, $urandom);

    @(posedge clk); #1;
    checkOutput("rsp_valid", 32'(rsp_valid), 32'(exp_grant));
    checkOutput("rsp_res", rsp_res, exp[31:0]);
    checkOutput("rsp_zero", 32'(rsp_zero), 32'(exp[31:0] == 32'd0));
    checkOutput("rsp_ovf", 32'(rsp_ovf), 32'(exp[32]));
    held_res = exp[31:0];

    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      rsp_ready = ($urandom_range(0, 1) == 1) ? ~exp_grant : 2'b00;
      @(posedge clk); #1;
      checkOutput("hold_rsp_valid", 32'(rsp_valid), 32'(exp_grant));
      checkOutput("hold_rsp_res", rsp_res, held_res);
      checkOutput("hold_req_ready", 32'(req_ready), 32'd0);
      checkOutput("hold_busy", 32'(busy), 32'd1);
    end

    @(negedge clk);
    rsp_ready = exp_grant | (($urandom_range(0, 1) == 1) ? ~exp_grant : 2'b00);
    if (!keep) req_valid = 2'b00;
    @(posedge clk); #1;
    m_prio = ~id;
    if (m_cnt < 65535) m_cnt++;
    checkOutput("done_busy", 32'(busy), 32'd0);
    checkOutput("done_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("op_cnt", 32'(op_cnt), 32'(m_cnt));
    if (keep) begin
      checkOutput("next_grant", 32'(req_ready), 32'(m_prio ? 2'b10 : 2'b01));
    end
  endtask

  // Pulse reset for one edge with no requests and restart the model.
  task automatic resetDut();
    @(negedge clk);
    rst       = 1'b1;
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    @(posedge clk); #1;
    checkOutput("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst    = 1'b0;
    m_cnt  = 0;
    m_prio = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    rsp_ready = 2'b00;
    m_cnt     = 0;
    m_prio    = 1'b0;
    applyStimulus(2'b11, OP_ADD, 32'd1, 32'd2, OP_SUB, 32'd3, 32'd4);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_req_ready", 32'(req_ready), 32'd0);
    checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_op_cnt", 32'(op_cnt), 32'd0);
    checkOutput("reset_rsp_res", rsp_res, 32'd0);
    checkOutput("reset_rsp_zero", 32'(rsp_zero), 32'd0);
    checkOutput("reset_rsp_ovf", 32'(rsp_ovf), 32'd0);
    @(negedge clk);
    rst       = 1'b0;
    req_valid = 2'b00;

    // Directed arithmetic corner cases.
    runTxn(2'b01, OP_ADD, 32'h7FFF_FFFF, 32'd1, OP_AND, 32'd0, 32'd0, 0, 1'b0, 1'b0);
    runTxn(2'b10, OP_AND, 32'd0, 32'd0, OP_SUB, 32'd5, 32'd5, 0, 1'b0, 1'b0);
    runTxn(2'b10, OP_AND, 32'd0, 32'd0, OP_SLT, 32'hFFFF_FFFF, 32'd1, 0, 1'b0, 1'b0);
    runTxn(2'b01, OP_SUB, 32'h8000_0000, 32'd1, OP_AND, 32'd0, 32'd0, 0, 1'b0, 1'b0);

    // Long response stall.
    runTxn(2'b01, OP_XOR, 32'hA5A5_0F0F, 32'h0F0F_A5A5, OP_OR, 32'd1, 32'd2, 5, 1'b0, 1'b0);

    // Both requesters continuously valid: round-robin alternates while the
    // fixed-priority instance keeps granting requester 0.
    resetDut();
    for (int i = 0; i < 4; i++) begin
      runTxn(2'b11, OP_ADD, 32'(i), 32'd10, OP_NOR, 32'(i), 32'd3, 0, 1'b1, 1'b1);
    end
    @(negedge clk);
    req_valid = 2'b00;
    @(posedge clk); #1;
    checkOutput("drain_busy", 32'(busy), 32'd0);

    // Reset while in EXEC aborts the transaction.
    @(negedge clk);
    applyStimulus(2'b01, OP_ADD, 32'd7, 32'd8, OP_AND, 32'd0, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst       = 1'b1;
    req_valid = 2'b11;
    #1;
    checkOutput("rst_exec_req_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    checkOutput("rst_exec_busy", 32'(busy), 32'd0);
    checkOutput("rst_exec_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rst_exec_op_cnt", 32'(op_cnt), 32'd0);
    checkOutput("rst_exec_res", rsp_res, 32'd0);
    @(negedge clk);
    rst       = 1'b0;
    req_valid = 2'b00;
    m_cnt     = 0;
    m_prio    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);

    // Reset while in RESP drops rsp_valid immediately.
    @(negedge clk);
    applyStimulus(2'b10, OP_AND, 32'd0, 32'd0, OP_OR, 32'h10, 32'h01);
    rsp_ready = 2'b00;
    @(posedge clk);
    @(negedge clk);
    req_valid = 2'b00;
    @(posedge clk); #1;
    checkOutput("pre_rst_rsp_valid", 32'(rsp_valid), 32'd2);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("rst_resp_rsp_valid", 32'(rsp_valid), 32'd0);
    @(posedge clk); #1;
    checkOutput("rst_resp_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst    = 1'b0;
    m_cnt  = 0;
    m_prio = 1'b0;

    // Randomised traffic against the reference model.
    for (int n = 0; n < 40; n++) begin
      r_valid = 2'($urandom_range(0, 3));
      r_op0   = 3'($urandom_range(0, 7));
      r_op1   = 3'($urandom_range(0, 7));
      r_a0    = $urandom;
      r_a1    = $urandom;
      r_b0    = (r_op0 == OP_SRL) ? 32'($urandom_range(0, 40)) :
                ($urandom_range(0, 3) == 0) ? r_a0 : $urandom;
      r_b1    = (r_op1 == OP_SRL) ? 32'($urandom_range(0, 40)) :
                ($urandom_range(0, 3) == 0) ? r_a1 : $urandom;
      if (r_valid == 2'b00) begin
        @(negedge clk);
        applyStimulus(2'b00, r_op0, r_a0, r_b0, r_op1, r_a1, r_b1);
        #1;
        checkOutput("idle_none_ready", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        checkOutput("idle_none_busy", 32'(busy), 32'd0);
      end else begin
        runTxn(r_valid, r_op0, r_a0, r_b0, r_op1, r_a1, r_b1,
               $urandom_range(0, 2), 1'b0, 1'b0);
      end
    end

    // Counter saturation: preload just below the ceiling.
    @(negedge clk);
    req_valid = 2'b00;
    force dut.op_cnt_q = 16'hFFFE;
    @(posedge clk);
    @(negedge clk);
    release dut.op_cnt_q;
    #1;
    checkOutput("preload_op_cnt", 32'(op_cnt), 32'h0000_FFFE);
    m_cnt = 32'h0000_FFFE;
    for (int i = 0; i < 3; i++) begin
      runTxn(2'b01, OP_OR, 32'(i), 32'd1, OP_AND, 32'd0, 32'd0, 0, 1'b0, 1'b0);
    end
    checkOutput("sat_op_cnt", 32'(op_cnt), 32'h0000_FFFF);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: PRI_FIXED, 0, 0 = round-robin between requesters; 1 = requester 0 always wins.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous and active-high.
REQ-004 Port: req_valid  input  2  per-requester request valid (bit i = requester i).
REQ-005 Port: req_ready  output  2  per-requester request accept; transfer when req_valid[i] & req_ready[i].
REQ-006 Port: req_op0 / req_op1  input  3 each  ALU operation code of requester 0 / 1.
REQ-007 Port: req_a0, req_b0 / req_a1, req_b1  input  32 each  operands A, B of requester 0 / 1.
REQ-008 Port: rsp_valid  output  2  one-hot response valid to the owning requester.
REQ-009 Port: rsp_ready  input  2  per-requester response accept.
REQ-010 Port: rsp_res  output  32  ALU result of the transaction being returned.
REQ-011 Port: rsp_zero  output  1  1 when rsp_res == 0.
REQ-012 Port: rsp_ovf  output  1  signed overflow flag (see REQ-021).
REQ-013 Port: busy  output  1  1 in any state other than IDLE.
REQ-014 Port: op_cnt  output  16  completed-transaction counter, saturating.

Function
REQ-015 Op codes SHALL be: 000 AND, 001 OR, 010 ADD, 011 XOR, 100 NOR, 101 SRL (A >> B), 110 SUB (A-B), 111 SLT (result = {31'b0, sign of A-B}); all eight legal.
REQ-016 FSM SHALL have states IDLE, EXEC, RESP; IDLE -> EXEC on accept; EXEC -> RESP unconditionally; RESP -> IDLE when rsp_ready[owner].
REQ-017 In IDLE, req_ready SHALL be one-hot to the winner among asserted req_valid bits (combinational), 0 if none; req_ready SHALL be 0 in EXEC and RESP.
REQ-018 Round-robin: on both valid, grant the requester not served last; pointer updates on response completion only; after reset requester 0 has priority.
REQ-019 On accept, op, A, B and owner id SHALL be registered; the ALU SHALL operate only on registered operands.
REQ-020 In EXEC, ALU result and zero SHALL be registered into rsp_res / rsp_zero; these hold stable throughout RESP.
REQ-021 rsp_ovf SHALL be computed from registered operands: ADD: A[31]==B[31] & S[31]!=A[31]; SUB: A[31]!=B[31] & S[31]!=A[31]; 0 for all other ops.
REQ-022 Latency: accept in cycle T -> rsp_valid[owner] high from cycle T+2; held with stable data until rsp_ready[owner]; minimum 3 cycles per transaction.
REQ-023 rsp_ready on the non-owner bit SHALL be ignored; rsp_valid SHALL be 0 outside RESP.
REQ-024 A requester dropping req_valid while not granted SHALL lose nothing; no request is queued internally.
REQ-025 op_cnt SHALL increment on each RESP -> IDLE transition; holds at 16'hFFFF.
REQ-026 A new request SHALL NOT be accepted in the cycle a response completes (IDLE is always entered first).

Reset
REQ-027 rst SHALL force, at the next clock edge: state IDLE, rsp_res 0, rsp_zero 0, rsp_ovf 0, op_cnt 0, RR pointer to requester 0, registered operands/id 0.
REQ-028 rst during EXEC or RESP SHALL abort the transaction; no rsp_valid is produced for it.
REQ-029 While rst is high, req_ready and rsp_valid SHALL be 0.

Structure
REQ-030 Shared package SHALL hold the 3-bit op-code constants (AND..SLT), the FSM state enum, and the 16-bit counter width.
REQ-031 One sub-module: the team's existing 32-bit ALU, instantiated once, fed from the registered operand/op registers.
REQ-032 Overflow logic and arbitration SHALL reside in alu_arbiter, not in the ALU.

Verification
REQ-033 Req0 ADD A=32'h7FFFFFFF B=1, rsp_ready=1 -> rsp_valid=01 at T+2, rsp_res=32'h80000000, rsp_ovf=1, rsp_zero=0.
REQ-034 Req1 SUB A=5 B=5 -> rsp_valid=10, rsp_res=0, rsp_zero=1, rsp_ovf=0; SLT A=32'hFFFFFFFF B=1 -> rsp_res=1.
REQ-035 Both valid continuously, PRI_FIXED=0 -> grants alternate 0,1,0,1; PRI_FIXED=1 -> always 0.
REQ-036 Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid and rsp_res stable, req_ready=00, busy=1; completes on rsp_ready.
REQ-037 Assert rst in EXEC -> next cycle IDLE, busy=0, no rsp_valid, op_cnt unchanged-to-0.
REQ-038 Force op_cnt to 16'hFFFE, run 3 transactions -> op_cnt stops at 16'hFFFF.
